spike_event_logger: RTL and testbench

- Downstream consumer of the SPI neural-network core's `monitor_spikes` vector.
- Timestamps every cycle that has a non-zero spike vector and buffers `{timestamp, spike_vector}` events in a first-word-fall-through (FWFT) FIFO.
- Exposes the FIFO through a valid/ready read port.
- Keeps saturating per-neuron spike counters, a dropped-event counter and a sticky overflow flag, so host logic can drain spike history without losing count information.

---
 rtl/spike_event_logger.sv | 120 ++++++++++++
 tb/tb_spike_event_logger.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_logger.sv
// Spike event logger: timestamps non-zero spike vectors into a FWFT FIFO and
// keeps saturating per-neuron spike counters plus drop/overflow bookkeeping.
module spike_event_logger #(
  parameter int NUM_NEURONS = 4,
  parameter int TS_WIDTH    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_WIDTH   = 16,
  parameter int DROP_WIDTH  = 8
) (
  input  logic                             sclk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             en,
  input  logic [NUM_NEURONS-1:0]           spikes_in,
  output logic                             evt_valid,
  input  logic                             evt_ready,
  output logic [TS_WIDTH+NUM_NEURONS-1:0]  evt_data,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_count,
  output logic                             overflow,
  output logic [DROP_WIDTH-1:0]            drop_count,
  output logic [NUM_NEURONS*CNT_WIDTH-1:0] spike_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = TS_WIDTH + NUM_NEURONS;

  logic [DW-1:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [TS_WIDTH-1:0]  ts;
  logic [CNT_WIDTH-1:0] cnt [NUM_NEURONS];

  logic push_req;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign push_req = en && (spikes_in != '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign pop      = (count != '0) && evt_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  assign evt_valid  = (count != '0);
  assign evt_data   = evt_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_pack
    assign spike_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt[g];
  end

  // Storage needs no reset: visibility is governed entirely by count.
  always_ff @(posedge sclk) begin
    if (!clr && push) begin
      mem[wr_ptr] <= {ts, spikes_in};
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ts         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ts         <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (en) begin
        ts <= ts + TS_WIDTH'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + DROP_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        cnt[i] <= '0;
      end
    end else if (en) begin
      for (int unsigned i = 0; i < NUM_NEURONS; i++) begin
        if (spikes_in[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_event_logger.sv
// Self-checking bench for spike_event_logger: directed scenarios plus random
// traffic, compared against a queue-based event/counter model.
module tb_spike_event_logger;

  logic        sclk;
  logic        rst_n;
  logic        clr;
  logic        en;
  logic [3:0]  spikes_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [19:0] evt_data;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;
  logic [63:0] spike_count;

  int checks   = 0;
  int failures = 0;

  // Model state
  logic [19:0] q[$];
  int unsigned m_ts;
  int unsigned m_cnt [4];
  int unsigned m_drop;
  bit          m_ovf;

  spike_event_logger #(
    .NUM_NEURONS(4),
    .TS_WIDTH   (16),
    .FIFO_DEPTH (8),
    .CNT_WIDTH  (16),
    .DROP_WIDTH (8)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .clr        (clr),
    .en         (en),
    .spikes_in  (spikes_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .drop_count (drop_count),
    .spike_count(spike_count)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ts   = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    bit pop;
    if (clr) begin
      model_reset();
      return;
    end
    pop = (q.size() != 0) && evt_ready;
    if (pop) void'(q.pop_front());
    if (en && spikes_in != 4'd0) begin
      if (q.size() < 8) q.push_back({m_ts[15:0], spikes_in});
      else begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    if (en) begin
      for (int i = 0; i < 4; i++)
        if (spikes_in[i] && m_cnt[i] < 65535) m_cnt[i]++;
      m_ts = (m_ts + 1) % 65536;
    end
  endtask

  task automatic compare_all();
    logic [63:0] exp_spk;
    exp_spk = '0;
    for (int i = 0; i < 4; i++) exp_spk = exp_spk | (64'(m_cnt[i]) << (16 * i));
    check("evt_valid", evt_valid, q.size() != 0);
    check("evt_data", evt_data, (q.size() != 0) ? q[0] : 20'd0);
    check("fifo_count", fifo_count, q.size());
    check("overflow", overflow, m_ovf);
    check("drop_count", drop_count, m_drop);
    check("spike_count", spike_count, exp_spk);
  endtask

  // Inputs are applied 1 time unit after a rising edge; this advances one cycle.
  task automatic step(input bit chk);
    model_edge();
    @(posedge sclk);
    #1;
    if (chk) compare_all();
  endtask

  task automatic drive(input bit c, input bit e, input logic [3:0] s, input bit r);
    clr = c; en = e; spikes_in = s; evt_ready = r;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 4'd0, 0);
    model_reset();
    #12;
    check("reset_valid", evt_valid, 1'b0);
    check("reset_count", fifo_count, 4'd0);
    check("reset_spk", spike_count, 64'd0);
    @(posedge sclk);
    #1;
    rst_n = 1'b1;

    // Idle with enable: nothing captured
    drive(0, 1, 4'd0, 0);
    for (int i = 0; i < 10; i++) step(1);
    check("idle_count", fifo_count, 4'd0);

    // Two events at ts=3 and ts=5 with a consumer always ready
    drive(1, 0, 4'd0, 1);
    step(1);
    for (int c = 0; c < 7; c++) begin
      drive(0, 1, (c == 3) ? 4'b0011 : (c == 5) ? 4'b1000 : 4'b0000, 1);
      step(1);
      if (c == 3) check("ev_ts3", evt_data, {16'd3, 4'b0011});
      if (c == 5) check("ev_ts5", evt_data, {16'd5, 4'b1000});
    end
    check("spk_two_ev", spike_count, {16'd1, 16'd0, 16'd1, 16'd1});

    // Overflow: 10 pushes with no consumer, then drain
    drive(1, 0, 4'd0, 0);
    step(1);
    drive(0, 1, 4'b0001, 0);
    for (int i = 0; i < 10; i++) step(1);
    check("ovf_count", fifo_count, 4'd8);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drop", drop_count, 8'd2);
    check("ovf_spk0", spike_count[15:0], 16'd10);
    drive(0, 1, 4'd0, 1);
    for (int i = 0; i < 9; i++) step(1);
    check("drained_valid", evt_valid, 1'b0);

    // Full FIFO with simultaneous push and pop: no overflow
    drive(1, 0, 4'd0, 0);
    step(1);
    drive(0, 1, 4'b0100, 0);
    for (int i = 0; i < 8; i++) step(1);
    drive(0, 1, 4'b0100, 1);
    for (int i = 0; i < 5; i++) step(1);
    check("full_pp_count", fifo_count, 4'd8);
    check("full_pp_ovf", overflow, 1'b0);
    check("full_pp_head", evt_data, {16'd5, 4'b0100});

    // Timestamp wrap
    drive(1, 0, 4'd0, 0);
    step(1);
    drive(0, 1, 4'd0, 0);
    for (int i = 0; i < 65534; i++) step(0);
    compare_all();
    drive(0, 1, 4'b0110, 0);
    for (int i = 0; i < 3; i++) step(1);
    check("wrap_head", evt_data, {16'hFFFE, 4'b0110});
    drive(0, 1, 4'd0, 1);
    step(1);
    check("wrap_2nd", evt_data, {16'hFFFF, 4'b0110});
    step(1);
    check("wrap_3rd", evt_data, {16'h0000, 4'b0110});
    // clr wins over a simultaneous spike
    drive(1, 1, 4'b1111, 0);
    step(1);
    check("clr_count", fifo_count, 4'd0);
    check("clr_spk", spike_count, 64'd0);
    drive(0, 1, 4'b0010, 0);
    step(1);
    check("clr_ts0", evt_data, {16'd0, 4'b0010});

    // Asynchronous reset between edges with entries queued
    drive(0, 1, 4'b1001, 0);
    for (int i = 0; i < 3; i++) step(1);
    check("pre_rst_count", fifo_count, 4'd4);
    drive(0, 1, 4'd0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", evt_valid, 1'b0);
    check("arst_data", evt_data, 20'd0);
    check("arst_count", fifo_count, 4'd0);
    check("arst_spk", spike_count, 64'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
    drive(0, 1, 4'd0, 1);
    for (int i = 0; i < 3; i++) step(1);
    check("arst_no_stale", evt_valid, 1'b0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) != 0),
            ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            ($urandom_range(0, 2) == 0));
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
